// File: rtl/tqv_periph_initiator.sv
// Host-side TinyQV peripheral bus initiator: one transaction in flight, strobes for one cycle per
// wait state until data_ready or TIMEOUT strobe cycles elapse; the response holds until resp_ready.
module tqv_periph_initiator #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_status,
  output logic [31:0]       resp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_address,
  output logic [31:0]       bus_wdata,
  output logic [1:0]        bus_write_n,
  output logic [1:0]        bus_read_n,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ERROR   = 2'b10;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] bus_address_q, bus_address_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [1:0]        bus_write_n_q, bus_write_n_d;
  logic [1:0]        bus_read_n_q, bus_read_n_d;
  logic              resp_valid_q, resp_valid_d;
  logic [1:0]        resp_status_q, resp_status_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              req_legal;

  function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   size_mask = {24'h0, data[7:0]};
      2'b01:   size_mask = {16'h0, data[15:0]};
      default: size_mask = data;
    endcase
  endfunction

  always_comb begin
    req_legal = 1'b1;
    if (req_size == 2'b11) req_legal = 1'b0;
    if (req_size == 2'b01 && req_addr[0] != 1'b0) req_legal = 1'b0;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_legal = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    write_d       = write_q;
    size_d        = size_q;
    bus_address_d = bus_address_q;
    bus_wdata_d   = bus_wdata_q;
    bus_write_n_d = bus_write_n_q;
    bus_read_n_d  = bus_read_n_q;
    resp_valid_d  = resp_valid_q;
    resp_status_d = resp_status_q;
    resp_rdata_d  = resp_rdata_q;
    req_ready_d   = req_ready_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          write_d     = req_write;
          size_d      = req_size;
          if (req_legal) begin
            state_d       = ACCESS;
            timer_d       = 8'd0;
            bus_address_d = req_addr;
            bus_wdata_d   = size_mask(req_size, req_wdata);
            bus_write_n_d = req_write ? req_size : 2'b11;
            bus_read_n_d  = req_write ? 2'b11 : req_size;
          end else begin
            // Illegal size/alignment is answered without touching the bus.
            state_d       = RESP;
            resp_valid_d  = 1'b1;
            resp_status_d = ST_ERROR;
            resp_rdata_d  = 32'h0;
          end
        end
      end
      ACCESS: begin
        if (bus_ready) begin
          state_d       = RESP;
          bus_write_n_d = 2'b11;
          bus_read_n_d  = 2'b11;
          resp_valid_d  = 1'b1;
          resp_status_d = ST_OK;
          resp_rdata_d  = write_q ? 32'h0 : size_mask(size_q, bus_rdata);
        end else if (timer_q == TIMER_LAST) begin
          state_d       = RESP;
          bus_write_n_d = 2'b11;
          bus_read_n_d  = 2'b11;
          resp_valid_d  = 1'b1;
          resp_status_d = ST_TIMEOUT;
          resp_rdata_d  = 32'h0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d       = IDLE;
        bus_write_n_d = 2'b11;
        bus_read_n_d  = 2'b11;
        resp_valid_d  = 1'b0;
        req_ready_d   = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= 8'd0;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      bus_address_q <= '0;
      bus_wdata_q   <= 32'h0;
      bus_write_n_q <= 2'b11;
      bus_read_n_q  <= 2'b11;
      resp_valid_q  <= 1'b0;
      resp_status_q <= ST_OK;
      resp_rdata_q  <= 32'h0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      write_q       <= write_d;
      size_q        <= size_d;
      bus_address_q <= bus_address_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_write_n_q <= bus_write_n_d;
      bus_read_n_q  <= bus_read_n_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_rdata_q  <= resp_rdata_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign resp_rdata  = resp_rdata_q;
  assign busy        = busy_q;
  assign bus_address = bus_address_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_write_n = bus_write_n_q;
  assign bus_read_n  = bus_read_n_q;

endmodule

// File: tb/tb_tqv_periph_initiator.sv
// Directed bench for tqv_periph_initiator: expected responses are queued at issue time and
// popped by a negedge monitor on every response handshake; strobe cycles are tallied alongside.
module tb_tqv_periph_initiator;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_status;
  logic [31:0] resp_rdata;
  logic        busy;
  logic [5:0]  bus_address;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_write_n;
  logic [1:0]  bus_read_n;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] rdata;
  } resp_t;

  resp_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    strobe_total = 0;

  tqv_periph_initiator #(.ADDR_W(6), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_rdata(resp_rdata), .busy(busy),
    .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_write_n(bus_write_n), .bus_read_n(bus_read_n),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard side: one pop per handshake, plus strobe sanity on every strobe cycle.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n) begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp_unexpected: got status %0d rdata 0x%08h, expected no response",
                   resp_status, resp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("resp_status", {30'h0, resp_status}, {30'h0, e.status});
          check("resp_rdata", resp_rdata, e.rdata);
        end
      end
      if (bus_write_n != 2'b11 || bus_read_n != 2'b11) begin
        strobe_total++;
        check("strobe_exclusive", {31'h0, (bus_write_n != 2'b11 && bus_read_n != 2'b11)}, 32'h0);
        check("strobe_while_busy", {31'h0, busy}, 32'h1);
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic [5:0] a,
                       input logic [31:0] wd, input logic [1:0] es, input logic [31:0] er);
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!req_ready) check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    exp_q.push_back({es, er});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("wait_idle_expired", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_addr   = 6'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    bus_rdata  = 32'h0;
    bus_ready  = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_write_n", {30'h0, bus_write_n}, 32'h3);
    check("rst_read_n", {30'h0, bus_read_n}, 32'h3);
    check("rst_address", {26'h0, bus_address}, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_status", {30'h0, resp_status}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 32-bit write, ready tied high: exactly one strobe cycle
    s0 = strobe_total;
    issue(1'b1, 2'b10, 6'h00, 32'hE000_0000, 2'b00, 32'h0);
    @(negedge clk);
    check("w32_write_n", {30'h0, bus_write_n}, 32'h2);
    check("w32_read_n", {30'h0, bus_read_n}, 32'h3);
    check("w32_address", {26'h0, bus_address}, 32'h00);
    check("w32_wdata", bus_wdata, 32'hE000_0000);
    @(negedge clk);
    check("w32_resp_valid", {31'h0, resp_valid}, 32'h1);
    check("w32_strobe_gone", {30'h0, bus_write_n}, 32'h3);
    wait_idle(20);
    check("w32_strobe_cycles", strobe_total - s0, 32'd1);

    // 8-bit and 16-bit writes: write data masked to the access size
    issue(1'b1, 2'b00, 6'h07, 32'h1234_5678, 2'b00, 32'h0);
    @(negedge clk);
    check("w8_write_n", {30'h0, bus_write_n}, 32'h0);
    check("w8_wdata", bus_wdata, 32'h0000_0078);
    wait_idle(20);
    issue(1'b1, 2'b01, 6'h0A, 32'hCAFE_BABE, 2'b00, 32'h0);
    @(negedge clk);
    check("w16_write_n", {30'h0, bus_write_n}, 32'h1);
    check("w16_wdata", bus_wdata, 32'h0000_BABE);
    check("w16_address", {26'h0, bus_address}, 32'h0A);
    wait_idle(20);

    // 8-bit read, ready on the 3rd strobe cycle
    bus_rdata = 32'hDEAD_BEEF;
    bus_ready = 1'b0;
    s0 = strobe_total;
    issue(1'b0, 2'b00, 6'h05, 32'h0, 2'b00, 32'h0000_00EF);
    @(negedge clk);
    check("r8_read_n", {30'h0, bus_read_n}, 32'h0);
    check("r8_address", {26'h0, bus_address}, 32'h05);
    @(posedge clk);
    @(posedge clk);
    #1 bus_ready = 1'b1;
    @(posedge clk);
    #1 bus_ready = 1'b0;
    wait_idle(20);
    check("r8_strobe_cycles", strobe_total - s0, 32'd3);

    // 16-bit and 32-bit reads, ready high
    bus_ready = 1'b1;
    issue(1'b0, 2'b01, 6'h02, 32'h0, 2'b00, 32'h0000_BEEF);
    wait_idle(20);
    issue(1'b0, 2'b10, 6'h04, 32'h0, 2'b00, 32'hDEAD_BEEF);
    wait_idle(20);

    // Timeout: 16 strobe cycles with data_ready low
    bus_ready = 1'b0;
    s0 = strobe_total;
    issue(1'b0, 2'b01, 6'h28, 32'h0, 2'b01, 32'h0);
    @(negedge clk);
    check("to_read_n", {30'h0, bus_read_n}, 32'h1);
    check("to_address", {26'h0, bus_address}, 32'h28);
    wait_idle(60);
    check("to_strobe_cycles", strobe_total - s0, 32'd16);

    // Illegal requests: no strobe, ERROR status
    bus_ready = 1'b1;
    s0 = strobe_total;
    issue(1'b0, 2'b10, 6'h06, 32'h0, 2'b10, 32'h0);
    wait_idle(20);
    issue(1'b1, 2'b01, 6'h03, 32'hFFFF_FFFF, 2'b10, 32'h0);
    wait_idle(20);
    issue(1'b0, 2'b11, 6'h00, 32'h0, 2'b10, 32'h0);
    wait_idle(20);
    check("illegal_strobe_cycles", strobe_total - s0, 32'd0);

    // Response backpressure with a competing request held on the port
    bus_rdata  = 32'h1234_56A5;
    resp_ready = 1'b0;
    issue(1'b0, 2'b00, 6'h01, 32'h0, 2'b00, 32'h0000_00A5);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 6'h03;
    req_wdata = 32'h0000_0155;
    exp_q.push_back({2'b00, 32'h0});
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
      check("bp_resp_status", {30'h0, resp_status}, 32'h0);
      check("bp_resp_rdata", resp_rdata, 32'h0000_00A5);
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
      check("bp_no_strobe", {30'h0, bus_write_n}, 32'h3);
      @(posedge clk);
    end
    #1 resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_after_hs_req_ready", {31'h0, req_ready}, 32'h1);
    check("bp_after_hs_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("bp_after_hs_no_strobe", {30'h0, bus_write_n}, 32'h3);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_second_write_n", {30'h0, bus_write_n}, 32'h0);
    check("bp_second_wdata", bus_wdata, 32'h0000_0055);
    wait_idle(20);

    // Asynchronous reset on the 2nd strobe cycle of a read
    bus_ready = 1'b0;
    issue(1'b0, 2'b10, 6'h08, 32'h0, 2'b00, 32'h0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    check("rst_mid_strobe_on", {30'h0, bus_read_n}, 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_read_n", {30'h0, bus_read_n}, 32'h3);
    check("rst_mid_write_n", {30'h0, bus_write_n}, 32'h3);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);

    // Normal operation resumes after reset
    bus_ready = 1'b1;
    issue(1'b1, 2'b00, 6'h3F, 32'hA5A5_A5A5, 2'b00, 32'h0);
    @(negedge clk);
    check("post_rst_address", {26'h0, bus_address}, 32'h3F);
    check("post_rst_wdata", bus_wdata, 32'h0000_00A5);
    wait_idle(20);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
